sram_frame_arbiter: RTL and testbench
=====================================

Name: sram_frame_arbiter

Overview:
- Owns the single external 16-bit SRAM that holds the two frame buffers.
- Shares the SRAM between two requesters:
  - the display reader, which feeds VGA scan-out;
  - the compute engine, which runs the simulation step and writes the next frame.
- Drives address, WE_N, OE_N and write data into the existing tristate/sync path.
- Maps each requester to its half of SRAM via even_frame, and performs frame swaps atomically between accesses.

Parameters:
- ACCESS_CYCLES, 2: cycles the address/control are held per SRAM access (1..7).
- STARVE_LIMIT, 4: consecutive display grants allowed while compute waits before compute is forced in (1..15).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read request; hold until disp_gnt
- disp_addr  in  19  display word address within the frame
- disp_gnt  out  1  1-cycle pulse: request accepted, address latched
- disp_rvalid  out  1  1-cycle pulse: disp_rdata valid
- disp_rdata  out  16  display read data, held until next rvalid
- comp_req  in  1  compute request; hold until comp_gnt
- comp_we  in  1  1 = write, 0 = read
- comp_addr  in  19  compute word address
- comp_wdata  in  16  compute write data
- comp_gnt  out  1  1-cycle pulse: accepted, address/data/we latched
- comp_done  out  1  1-cycle pulse: access complete (comp_rdata valid if read)
- comp_rdata  out  16  compute read data
- swap_req  in  1  level; request frame swap
- swap_ack  out  1  1-cycle pulse: swap performed
- even_frame  out  1  current display buffer select
- SRAM_ADDRESS  out  20  {bank bit, word address}
- SRAM_WE_N  out  1  active-low write enable
- SRAM_OE_N  out  1  active-low output enable
- Data_to_SRAM  out  16  write data to tristate
- Data_from_SRAM  in  16  read data from tristate

Behaviour:
- All outputs registered.
- Reset values:
  - SRAM_WE_N = 1, SRAM_OE_N = 1
  - SRAM_ADDRESS = 0, Data_to_SRAM = 0
  - disp_rdata = 0, comp_rdata = 0
  - all pulses = 0, even_frame = 1
  - FSM = IDLE, starve counter = 0
- Banking:
  - display: SRAM_ADDRESS[19] = even_frame;
  - compute: SRAM_ADDRESS[19] = ~even_frame;
  - SRAM_ADDRESS[18:0] = the latched requester address.
- States: IDLE, ACCESS, TURN.
- IDLE: arbitrate every cycle, in this priority order:
  1. swap_req: toggle even_frame, pulse swap_ack next cycle, stay IDLE, grant nothing this cycle.
  2. Compute, if comp_req and (starve count == STARVE_LIMIT or !disp_req).
  3. Display, if disp_req.
  4. Otherwise stay IDLE.
- On a grant:
  - latch the address (plus comp_we/comp_wdata for compute) and go to ACCESS;
  - the gnt pulse appears in the first ACCESS cycle;
  - the requester may change or drop inputs from that cycle on.
- ACCESS lasts exactly ACCESS_CYCLES cycles with address stable:
  - read: OE_N = 0, WE_N = 1;
  - write: WE_N = 0, OE_N = 1, Data_to_SRAM = latched wdata.
- Read capture: Data_from_SRAM is sampled on the clock edge ending the last ACCESS cycle.
- Read completion:
  - return to IDLE;
  - rvalid/done pulses in that IDLE cycle with data.
- Write completion:
  - go to TURN (WE_N = OE_N = 1, bus turnaround), then IDLE;
  - comp_done pulses in the TURN cycle.
- Latency:
  - read: request seen in IDLE cycle 0 → rvalid in cycle ACCESS_CYCLES+1;
  - write: done in cycle ACCESS_CYCLES+1, next grant no earlier than cycle ACCESS_CYCLES+2.
- Starve counter:
  - increments on each display grant while comp_req = 1, saturating at STARVE_LIMIT;
  - clears on a compute grant or whenever comp_req = 0.
- Simultaneous events:
  - swap_req with pending requests: swap wins, requests wait one cycle;
  - swap_req during ACCESS/TURN: deferred to the next IDLE, never mid-access.
- The bank bit of an in-flight access is fixed at grant.
- Reset mid-access: access aborted, WE_N/OE_N high on the next cycle, no gnt/done/rvalid pulse.
- WE_N and OE_N are never both 0.

Decomposition:
- Shared package sram_frame_pkg:
  - state enum {IDLE, ACCESS, TURN};
  - owner enum {OWN_DISP, OWN_COMP};
  - constants FRAME_BIT = 19, WORD_AW = 19, DW = 16.
- One sub-module: sram_arb_pick (combinational priority/starvation decision plus registered starve counter).

Test Plan:
- Reset, then a single display read, disp_addr = 0x00010, SRAM preloaded 0xBEEF at 0x80010 → with ACCESS_CYCLES = 2: disp_gnt in cycle 1, OE_N low cycles 1-2, SRAM_ADDRESS = 0x80010, disp_rvalid in cycle 3 with rdata 0xBEEF.
- Compute write, addr 0x00005, data 0x1234 → WE_N low for exactly 2 cycles at SRAM_ADDRESS = 0x00005, comp_done in TURN cycle; a later compute read returns 0x1234.
- disp_req held high continuously with comp_req high → exactly 4 display grants, then 1 compute grant, repeating; comp never waits more than 4 display accesses.
- swap_req asserted mid display read → access completes on the original bank, swap_ack one cycle after return to IDLE, even_frame = 0, next display read uses bank bit 0.
- Reset asserted in the 2nd cycle of a write → WE_N = 1 the next cycle, no comp_done, all outputs at reset values.
- Back-to-back write then display read → one TURN cycle with WE_N = OE_N = 1 between them; WE_N and OE_N never both low (assertion).

Source files
------------

// File: rtl/sram_frame_pkg.sv
// Shared types and constants for the SRAM frame-buffer arbiter.
package sram_frame_pkg;

   localparam int FRAME_BIT = 19;
   localparam int WORD_AW   = 19;
   localparam int DW        = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      TURN
   } state_t;

   typedef enum logic {
      OWN_DISP,
      OWN_COMP
   } owner_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Priority decision between display and compute, with the starvation counter
// that forces compute in after STARVE_LIMIT back-to-back display grants.
module sram_arb_pick
   import sram_frame_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic arb_en,
   input  logic disp_req,
   input  logic comp_req,
   output logic grant_disp,
   output logic grant_comp
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   logic       starved;

   // Compute wins when display is quiet or has used up its allowance.
   always_comb begin
      starved    = (starve_cnt == LIMIT);
      grant_comp = arb_en && comp_req && (starved || !disp_req);
      grant_disp = arb_en && disp_req && !grant_comp;
   end

   // Count display grants that overtook a waiting compute request.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!comp_req || grant_comp) begin
         starve_cnt <= '0;
      end else if (grant_disp && !starved) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/sram_frame_arbiter.sv
// Single-port SRAM arbiter for the double-buffered frame store.
//
//  state  | meaning
//  IDLE   | arbitrate: swap first, then compute/display; read results pulse here
//  ACCESS | address/control held for ACCESS_CYCLES cycles
//  TURN   | one bus-turnaround cycle after a write, comp_done pulses here
module sram_frame_arbiter
   import sram_frame_pkg::*;
#(
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 disp_req,
   input  logic [WORD_AW-1:0]   disp_addr,
   output logic                 disp_gnt,
   output logic                 disp_rvalid,
   output logic [DW-1:0]        disp_rdata,
   input  logic                 comp_req,
   input  logic                 comp_we,
   input  logic [WORD_AW-1:0]   comp_addr,
   input  logic [DW-1:0]        comp_wdata,
   output logic                 comp_gnt,
   output logic                 comp_done,
   output logic [DW-1:0]        comp_rdata,
   input  logic                 swap_req,
   output logic                 swap_ack,
   output logic                 even_frame,
   output logic [FRAME_BIT:0]   SRAM_ADDRESS,
   output logic                 SRAM_WE_N,
   output logic                 SRAM_OE_N,
   output logic [DW-1:0]        Data_to_SRAM,
   input  logic [DW-1:0]        Data_from_SRAM
);

   localparam logic [2:0] ACC_LOAD = 3'(ACCESS_CYCLES - 1);

   state_t     state;
   owner_t     owner;
   logic       is_write;
   logic [2:0] acc_cnt;
   logic       swap_now;
   logic       arb_en;
   logic       grant_disp;
   logic       grant_comp;

   // A level swap request is not re-taken in the cycle its ack is showing,
   // so one held request swaps once and the blocked requester gets its turn.
   always_comb begin
      swap_now = (state == IDLE) && swap_req && !swap_ack;
      arb_en   = (state == IDLE) && !swap_now;
   end

   sram_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk       (Clk),
      .reset     (Reset),
      .arb_en    (arb_en),
      .disp_req  (disp_req),
      .comp_req  (comp_req),
      .grant_disp(grant_disp),
      .grant_comp(grant_comp)
   );

   // Main sequencer: all outputs registered, pulses default low every cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         owner        <= OWN_DISP;
         is_write     <= 1'b0;
         acc_cnt      <= '0;
         disp_gnt     <= 1'b0;
         disp_rvalid  <= 1'b0;
         disp_rdata   <= '0;
         comp_gnt     <= 1'b0;
         comp_done    <= 1'b0;
         comp_rdata   <= '0;
         swap_ack     <= 1'b0;
         even_frame   <= 1'b1;
         SRAM_ADDRESS <= '0;
         SRAM_WE_N    <= 1'b1;
         SRAM_OE_N    <= 1'b1;
         Data_to_SRAM <= '0;
      end else begin
         disp_gnt    <= 1'b0;
         disp_rvalid <= 1'b0;
         comp_gnt    <= 1'b0;
         comp_done   <= 1'b0;
         swap_ack    <= 1'b0;
         case (state)
            IDLE: begin
               if (swap_now) begin
                  even_frame <= ~even_frame;
                  swap_ack   <= 1'b1;
               end else if (grant_comp) begin
                  // Compute always works on the buffer not being displayed.
                  SRAM_ADDRESS <= {~even_frame, comp_addr};
                  owner        <= OWN_COMP;
                  is_write     <= comp_we;
                  if (comp_we) begin
                     SRAM_WE_N    <= 1'b0;
                     Data_to_SRAM <= comp_wdata;
                  end else begin
                     SRAM_OE_N    <= 1'b0;
                  end
                  comp_gnt <= 1'b1;
                  acc_cnt  <= ACC_LOAD;
                  state    <= ACCESS;
               end else if (grant_disp) begin
                  SRAM_ADDRESS <= {even_frame, disp_addr};
                  owner        <= OWN_DISP;
                  is_write     <= 1'b0;
                  SRAM_OE_N    <= 1'b0;
                  disp_gnt     <= 1'b1;
                  acc_cnt      <= ACC_LOAD;
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               if (acc_cnt == 3'd0) begin
                  SRAM_WE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  if (is_write) begin
                     comp_done <= 1'b1;
                     state     <= TURN;
                  end else begin
                     if (owner == OWN_COMP) begin
                        comp_rdata <= Data_from_SRAM;
                        comp_done  <= 1'b1;
                     end else begin
                        disp_rdata  <= Data_from_SRAM;
                        disp_rvalid <= 1'b1;
                     end
                     state <= IDLE;
                  end
               end else begin
                  acc_cnt <= acc_cnt - 3'd1;
               end
            end
            TURN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Self-checking bench for sram_frame_arbiter with a behavioural SRAM and
// a transaction-level reference memory.
module tb_sram_frame_arbiter;

   localparam int ACC = 2;
   localparam int LIM = 4;

   logic        Clk, Reset;
   logic        disp_req, disp_gnt, disp_rvalid;
   logic [18:0] disp_addr;
   logic [15:0] disp_rdata;
   logic        comp_req, comp_we, comp_gnt, comp_done;
   logic [18:0] comp_addr;
   logic [15:0] comp_wdata, comp_rdata;
   logic        swap_req, swap_ack, even_frame;
   logic [19:0] SRAM_ADDRESS;
   logic        SRAM_WE_N, SRAM_OE_N;
   logic [15:0] Data_to_SRAM, Data_from_SRAM;

   int   errors = 0;
   int   checks = 0;
   logic ef_model;

   logic [15:0] sram    [int];
   logic [15:0] ref_mem [int];

   sram_frame_arbiter #(.ACCESS_CYCLES(ACC), .STARVE_LIMIT(LIM)) dut (
      .Clk(Clk), .Reset(Reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .comp_req(comp_req), .comp_we(comp_we), .comp_addr(comp_addr),
      .comp_wdata(comp_wdata), .comp_gnt(comp_gnt), .comp_done(comp_done),
      .comp_rdata(comp_rdata), .swap_req(swap_req), .swap_ack(swap_ack),
      .even_frame(even_frame), .SRAM_ADDRESS(SRAM_ADDRESS), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_OE_N(SRAM_OE_N), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Asynchronous SRAM: writes and read data settle mid-cycle.
   initial begin
      Data_from_SRAM = '0;
      forever begin
         @(negedge Clk);
         if (SRAM_WE_N === 1'b0) sram[int'(SRAM_ADDRESS)] = Data_to_SRAM;
         if (sram.exists(int'(SRAM_ADDRESS))) Data_from_SRAM = sram[int'(SRAM_ADDRESS)];
         else Data_from_SRAM = 16'h0;
      end
   end

   // WE_N and OE_N must never be low together.
   initial begin
      forever begin
         @(negedge Clk);
         if (Reset === 1'b0) begin
            checks++;
            if (SRAM_WE_N === 1'b0 && SRAM_OE_N === 1'b0) begin
               errors++;
               $display("FAIL we_oe_exclusive: WE_N=%b OE_N=%b, required not both 0", SRAM_WE_N, SRAM_OE_N);
            end
         end
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic preload(input logic [19:0] a, input logic [15:0] d);
      sram[int'(a)]    = d;
      ref_mem[int'(a)] = d;
   endtask

   function automatic logic [15:0] ref_rd(input logic [19:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
   endfunction

   task automatic run_disp(input logic [18:0] a, output logic [15:0] d,
                           output logic [19:0] seen, output int lat);
      int cyc = 0;
      bit got = 0;
      d = '0; seen = '0; lat = -1;
      disp_req = 1'b1; disp_addr = a;
      while (!got && cyc < 20) begin
         tick; cyc++;
         if (disp_gnt) begin got = 1; seen = SRAM_ADDRESS; disp_req = 1'b0; end
      end
      disp_req = 1'b0;
      if (got) begin
         got = 0;
         while (!got && cyc < 40) begin
            tick; cyc++;
            if (disp_rvalid) begin got = 1; d = disp_rdata; lat = cyc; end
         end
      end
      tick;
   endtask

   task automatic run_comp(input logic we, input logic [18:0] a, input logic [15:0] wd,
                           output logic [15:0] d, output logic [19:0] seen, output int lat);
      int cyc = 0;
      bit got = 0;
      d = '0; seen = '0; lat = -1;
      comp_req = 1'b1; comp_we = we; comp_addr = a; comp_wdata = wd;
      while (!got && cyc < 20) begin
         tick; cyc++;
         if (comp_gnt) begin got = 1; seen = SRAM_ADDRESS; comp_req = 1'b0; end
      end
      comp_req = 1'b0;
      if (got) begin
         got = 0;
         while (!got && cyc < 40) begin
            tick; cyc++;
            if (comp_done) begin got = 1; d = comp_rdata; lat = cyc; end
         end
      end
      tick;
   endtask

   task automatic run_swap(output int lat);
      int cyc = 0;
      lat = -1;
      swap_req = 1'b1;
      while (lat < 0 && cyc < 20) begin
         tick; cyc++;
         if (swap_ack) lat = cyc;
      end
      swap_req = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1; disp_req = 0; disp_addr = '0; comp_req = 0; comp_we = 0;
      comp_addr = '0; comp_wdata = '0; swap_req = 0;
      ef_model = 1'b1;
      tick; tick;
      checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %b want 1", SRAM_WE_N); end
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL rst_oe_n: got %b want 1", SRAM_OE_N); end
      checks++; if (SRAM_ADDRESS !== 20'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", SRAM_ADDRESS); end
      checks++; if (Data_to_SRAM !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", Data_to_SRAM); end
      checks++; if (disp_rdata !== 16'h0 || comp_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", disp_rdata, comp_rdata); end
      checks++; if ({disp_gnt, disp_rvalid, comp_gnt, comp_done, swap_ack} !== 5'b0) begin errors++; $display("FAIL rst_pulses: got %b want 00000", {disp_gnt, disp_rvalid, comp_gnt, comp_done, swap_ack}); end
      checks++; if (even_frame !== 1'b1) begin errors++; $display("FAIL rst_even_frame: got %b want 1", even_frame); end
      Reset = 1'b0;
      tick;
   endtask

   task automatic test_disp_read;
      preload(20'h80010, 16'hBEEF);
      preload(20'h00010, 16'h1111);
      disp_req = 1'b1; disp_addr = 19'h00010;
      tick;
      checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt_c1: got %b want 1", disp_gnt); end
      checks++; if (SRAM_OE_N !== 1'b0 || SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL rd_ctrl_c1: OE_N=%b WE_N=%b want 0/1", SRAM_OE_N, SRAM_WE_N); end
      checks++; if (SRAM_ADDRESS !== 20'h80010) begin errors++; $display("FAIL rd_addr_c1: got %h want 80010", SRAM_ADDRESS); end
      disp_req = 1'b0; disp_addr = 19'h7FFFF;
      tick;
      checks++; if (SRAM_OE_N !== 1'b0 || disp_gnt !== 1'b0) begin errors++; $display("FAIL rd_c2: OE_N=%b gnt=%b want 0/0", SRAM_OE_N, disp_gnt); end
      checks++; if (SRAM_ADDRESS !== 20'h80010) begin errors++; $display("FAIL rd_addr_c2: got %h want 80010", SRAM_ADDRESS); end
      tick;
      checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rvalid_c3: rvalid=%b data=%h want 1/beef", disp_rvalid, disp_rdata); end
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL rd_oe_c3: got %b want 1", SRAM_OE_N); end
      tick;
      checks++; if (disp_rvalid !== 1'b0 || disp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_hold_c4: rvalid=%b data=%h want 0/beef", disp_rvalid, disp_rdata); end
   endtask

   task automatic test_comp_write_read;
      int we_low = 0;
      int lat;
      logic [15:0] got;
      logic [19:0] seen;
      comp_req = 1'b1; comp_we = 1'b1; comp_addr = 19'h00005; comp_wdata = 16'h1234;
      tick;
      if (SRAM_WE_N === 1'b0) we_low++;
      checks++; if (comp_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt_c1: got %b want 1", comp_gnt); end
      checks++; if (SRAM_ADDRESS !== 20'h00005 || Data_to_SRAM !== 16'h1234) begin errors++; $display("FAIL wr_bus_c1: addr=%h data=%h want 00005/1234", SRAM_ADDRESS, Data_to_SRAM); end
      comp_req = 1'b0; comp_we = 1'b0; comp_wdata = 16'hFFFF;
      tick;
      if (SRAM_WE_N === 1'b0) we_low++;
      tick;
      if (SRAM_WE_N === 1'b0) we_low++;
      checks++; if (comp_done !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL wr_turn_c3: done=%b WE_N=%b OE_N=%b want 1/1/1", comp_done, SRAM_WE_N, SRAM_OE_N); end
      tick;
      if (SRAM_WE_N === 1'b0) we_low++;
      checks++; if (comp_done !== 1'b0) begin errors++; $display("FAIL wr_done_once: got %b want 0", comp_done); end
      checks++; if (we_low != ACC) begin errors++; $display("FAIL wr_we_width: got %0d want %0d", we_low, ACC); end
      ref_mem[int'(20'h00005)] = 16'h1234;
      run_comp(1'b0, 19'h00005, 16'h0, got, seen, lat);
      checks++; if (got !== 16'h1234) begin errors++; $display("FAIL wr_readback: got %h want 1234", got); end
      checks++; if (lat != ACC + 1 || seen !== 20'h00005) begin errors++; $display("FAIL cr_lat_addr: lat=%0d addr=%h want %0d/00005", lat, seen, ACC + 1); end
   endtask

   task automatic test_starve;
      int n = 0;
      int cyc = 0;
      bit last_done = 0;
      logic [15:0] exp_dd = '0;
      logic [15:0] exp_cd = '0;
      int own[$];
      disp_addr = 19'($urandom); comp_addr = 19'($urandom); comp_we = 1'b0;
      preload({ef_model, disp_addr}, 16'($urandom));
      preload({~ef_model, comp_addr}, 16'($urandom));
      disp_req = 1'b1; comp_req = 1'b1;
      while (n < 15 && cyc < 300) begin
         tick; cyc++;
         if (disp_rvalid) begin
            checks++; if (disp_rdata !== exp_dd) begin errors++; $display("FAIL st_drdata: got %h want %h", disp_rdata, exp_dd); end
         end
         if (comp_done) begin
            checks++; if (comp_rdata !== exp_cd) begin errors++; $display("FAIL st_crdata: got %h want %h", comp_rdata, exp_cd); end
         end
         if (disp_gnt) begin
            own.push_back(0); n++;
            checks++; if (SRAM_ADDRESS !== {ef_model, disp_addr}) begin errors++; $display("FAIL st_daddr: got %h want %h", SRAM_ADDRESS, {ef_model, disp_addr}); end
            exp_dd = ref_rd({ef_model, disp_addr});
            disp_addr = 19'($urandom);
            preload({ef_model, disp_addr}, 16'($urandom));
         end
         if (comp_gnt) begin
            own.push_back(1); n++;
            checks++; if (SRAM_ADDRESS !== {~ef_model, comp_addr}) begin errors++; $display("FAIL st_caddr: got %h want %h", SRAM_ADDRESS, {~ef_model, comp_addr}); end
            exp_cd = ref_rd({~ef_model, comp_addr});
            comp_addr = 19'($urandom);
            preload({~ef_model, comp_addr}, 16'($urandom));
         end
      end
      disp_req = 1'b0; comp_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick;
         if (comp_done) begin
            last_done = 1;
            checks++; if (comp_rdata !== exp_cd) begin errors++; $display("FAIL st_last_crdata: got %h want %h", comp_rdata, exp_cd); end
         end
      end
      checks++; if (n != 15 || !last_done) begin errors++; $display("FAIL st_timeout: grants=%0d last_done=%0d want 15/1", n, last_done); end
      for (int i = 0; i < own.size(); i++) begin
         checks++;
         if (own[i] != ((i % (LIM + 1)) == LIM ? 1 : 0)) begin
            errors++; $display("FAIL st_order[%0d]: got owner %0d want %0d", i, own[i], ((i % (LIM + 1)) == LIM ? 1 : 0));
         end
      end
   endtask

   task automatic test_swap;
      preload(20'h80123, 16'h5A5A);
      preload(20'h00123, 16'hA5A5);
      disp_req = 1'b1; disp_addr = 19'h00123;
      tick;
      checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL sw_gnt1: got %b want 1", disp_gnt); end
      disp_req = 1'b0; swap_req = 1'b1;
      tick;
      checks++; if (even_frame !== 1'b1 || swap_ack !== 1'b0 || SRAM_ADDRESS !== 20'h80123) begin errors++; $display("FAIL sw_midaccess: ef=%b ack=%b addr=%h want 1/0/80123", even_frame, swap_ack, SRAM_ADDRESS); end
      tick;
      checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'h5A5A) begin errors++; $display("FAIL sw_orig_bank: rvalid=%b data=%h want 1/5a5a", disp_rvalid, disp_rdata); end
      checks++; if (even_frame !== 1'b1 || swap_ack !== 1'b0) begin errors++; $display("FAIL sw_not_yet: ef=%b ack=%b want 1/0", even_frame, swap_ack); end
      disp_req = 1'b1;
      tick;
      checks++; if (swap_ack !== 1'b1 || even_frame !== 1'b0) begin errors++; $display("FAIL sw_ack: ack=%b ef=%b want 1/0", swap_ack, even_frame); end
      checks++; if (disp_gnt !== 1'b0) begin errors++; $display("FAIL sw_wins: disp_gnt=%b want 0", disp_gnt); end
      swap_req = 1'b0; ef_model = 1'b0;
      tick;
      checks++; if (disp_gnt !== 1'b1 || SRAM_ADDRESS !== 20'h00123) begin errors++; $display("FAIL sw_new_bank: gnt=%b addr=%h want 1/00123", disp_gnt, SRAM_ADDRESS); end
      disp_req = 1'b0;
      tick; tick;
      checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'hA5A5) begin errors++; $display("FAIL sw_new_data: rvalid=%b data=%h want 1/a5a5", disp_rvalid, disp_rdata); end
      tick;
   endtask

   task automatic test_reset_mid_write;
      comp_req = 1'b1; comp_we = 1'b1; comp_addr = 19'h7FFFF; comp_wdata = 16'hC0DE;
      tick;
      checks++; if (comp_gnt !== 1'b1 || SRAM_WE_N !== 1'b0 || SRAM_ADDRESS !== 20'hFFFFF) begin errors++; $display("FAIL rw_start: gnt=%b WE_N=%b addr=%h want 1/0/fffff", comp_gnt, SRAM_WE_N, SRAM_ADDRESS); end
      comp_req = 1'b0; comp_we = 1'b0;
      tick;
      Reset = 1'b1;
      tick;
      checks++; if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL rw_ctrl: WE_N=%b OE_N=%b want 1/1", SRAM_WE_N, SRAM_OE_N); end
      checks++; if ({disp_gnt, disp_rvalid, comp_gnt, comp_done, swap_ack} !== 5'b0) begin errors++; $display("FAIL rw_pulses: got %b want 00000", {disp_gnt, disp_rvalid, comp_gnt, comp_done, swap_ack}); end
      checks++; if (SRAM_ADDRESS !== 20'h0 || Data_to_SRAM !== 16'h0) begin errors++; $display("FAIL rw_bus: addr=%h data=%h want 0/0", SRAM_ADDRESS, Data_to_SRAM); end
      checks++; if (disp_rdata !== 16'h0 || comp_rdata !== 16'h0) begin errors++; $display("FAIL rw_rdata: got %h/%h want 0/0", disp_rdata, comp_rdata); end
      checks++; if (even_frame !== 1'b1) begin errors++; $display("FAIL rw_even_frame: got %b want 1", even_frame); end
      Reset = 1'b0; ef_model = 1'b1;
      tick;
      checks++; if (comp_done !== 1'b0 || SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL rw_after: done=%b WE_N=%b want 0/1", comp_done, SRAM_WE_N); end
      tick;
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [15:0] got;
      logic [19:0] seen;
      preload(20'h80042, 16'h7777);
      comp_req = 1'b1; comp_we = 1'b1; comp_addr = 19'h00042; comp_wdata = 16'h4242;
      tick;
      checks++; if (comp_gnt !== 1'b1) begin errors++; $display("FAIL bb_cgnt: got %b want 1", comp_gnt); end
      comp_req = 1'b0; comp_we = 1'b0;
      disp_req = 1'b1; disp_addr = 19'h00042;
      tick; tick;
      checks++; if (comp_done !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || disp_gnt !== 1'b0) begin errors++; $display("FAIL bb_turn: done=%b WE_N=%b OE_N=%b dgnt=%b want 1/1/1/0", comp_done, SRAM_WE_N, SRAM_OE_N, disp_gnt); end
      tick;
      checks++; if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || disp_gnt !== 1'b0) begin errors++; $display("FAIL bb_idle: WE_N=%b OE_N=%b dgnt=%b want 1/1/0", SRAM_WE_N, SRAM_OE_N, disp_gnt); end
      tick;
      checks++; if (disp_gnt !== 1'b1 || SRAM_OE_N !== 1'b0 || SRAM_ADDRESS !== 20'h80042) begin errors++; $display("FAIL bb_dgnt: gnt=%b OE_N=%b addr=%h want 1/0/80042", disp_gnt, SRAM_OE_N, SRAM_ADDRESS); end
      disp_req = 1'b0;
      tick; tick;
      checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'h7777) begin errors++; $display("FAIL bb_ddata: rvalid=%b data=%h want 1/7777", disp_rvalid, disp_rdata); end
      tick;
      ref_mem[int'(20'h00042)] = 16'h4242;
      run_comp(1'b0, 19'h00042, 16'h0, got, seen, lat);
      checks++; if (got !== ref_rd(20'h00042)) begin errors++; $display("FAIL bb_readback: got %h want %h", got, ref_rd(20'h00042)); end
   endtask

   task automatic test_random;
      logic [18:0] a;
      logic [15:0] d, got;
      logic [19:0] seen;
      int lat, op;
      for (int k = 0; k < 8; k++) begin
         preload({1'b0, 19'h100 + 19'(k)}, 16'($urandom));
         preload({1'b1, 19'h100 + 19'(k)}, 16'($urandom));
      end
      for (int i = 0; i < 30; i++) begin
         op = $urandom_range(0, 3);
         a  = 19'h100 + 19'($urandom_range(0, 7));
         d  = 16'($urandom);
         case (op)
            0: begin
               run_disp(a, got, seen, lat);
               checks++; if (seen !== {ef_model, a} || got !== ref_rd({ef_model, a}) || lat != ACC + 1) begin errors++; $display("FAIL rnd_disp[%0d]: addr=%h data=%h lat=%0d want %h/%h/%0d", i, seen, got, lat, {ef_model, a}, ref_rd({ef_model, a}), ACC + 1); end
            end
            1: begin
               run_comp(1'b1, a, d, got, seen, lat);
               ref_mem[int'({~ef_model, a})] = d;
               checks++; if (seen !== {~ef_model, a} || lat != ACC + 1) begin errors++; $display("FAIL rnd_cwr[%0d]: addr=%h lat=%0d want %h/%0d", i, seen, lat, {~ef_model, a}, ACC + 1); end
            end
            2: begin
               run_comp(1'b0, a, d, got, seen, lat);
               checks++; if (seen !== {~ef_model, a} || got !== ref_rd({~ef_model, a}) || lat != ACC + 1) begin errors++; $display("FAIL rnd_crd[%0d]: addr=%h data=%h lat=%0d want %h/%h/%0d", i, seen, got, lat, {~ef_model, a}, ref_rd({~ef_model, a}), ACC + 1); end
            end
            default: begin
               run_swap(lat);
               ef_model = ~ef_model;
               checks++; if (lat != 1 || even_frame !== ef_model) begin errors++; $display("FAIL rnd_swap[%0d]: lat=%0d ef=%b want 1/%b", i, lat, even_frame, ef_model); end
               tick;
            end
         endcase
      end
   endtask

   initial begin
      test_reset;
      test_disp_read;
      test_comp_write_read;
      test_starve;
      test_swap;
      test_reset_mid_write;
      test_back_to_back;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
